// File: rtl/alu_pkg.sv
// Shared types for the ALU-sharing arbiter: ALU op codes, FSM states and
// the op-code legality check used to gate the ALU result.
package alu_pkg;

  localparam int DATA_W  = 32;
  localparam int MAX_REQ = 4;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } arb_state_e;

  function automatic logic is_legal_op(input alu_op_e op);
    return op inside {ALU_AND, ALU_OR, ALU_ADD, ALU_SUB};
  endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between NREQ requesters and the shared ALU arbiter.
interface alu_share_arbiter_if #(
  parameter int NREQ = 2
);
  // Handshakes: a transfer on index i happens on the rising edge where both
  // valid[i] and ready[i] are high. Requests may drop valid before grant;
  // resp_valid, resp_result, resp_zero and resp_err hold until resp_ready.
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0][31:0] req_op1;
  logic [NREQ-1:0][31:0] req_op2;
  logic [NREQ-1:0][3:0]  req_aluop;
  logic [NREQ-1:0]       resp_valid;
  logic [NREQ-1:0]       resp_ready;
  logic [31:0]           resp_result;
  logic                  resp_zero;
  logic                  resp_err;

  modport master (
    output req_valid, req_op1, req_op2, req_aluop, resp_ready,
    input  req_ready, resp_valid, resp_result, resp_zero, resp_err
  );

  modport slave (
    input  req_valid, req_op1, req_op2, req_aluop, resp_ready,
    output req_ready, resp_valid, resp_result, resp_zero, resp_err
  );

endinterface

// File: rtl/alu_share_arbiter_alu.sv
// Combinational 32-bit ALU (AND/OR/ADD/SUB). Unknown codes yield 0 so the
// output is always a pure function of the current inputs.
module alu_share_arbiter_alu
  import alu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_e     op,
  output logic [31:0] result
);

  always_comb begin
    result = '0;
    case (op)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between NREQ requesters: grant one, register its operands,
// execute for one cycle, then hold the response until it is consumed.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ        = 2,
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  alu_share_arbiter_if.slave  ifc,
  output logic                busy,
  output arb_state_e          state_dbg,
  output logic [1:0]          rr_ptr_dbg
);

  localparam logic [1:0] LAST_IDX = 2'(NREQ - 1);

  arb_state_e  state_q, state_d;
  logic [1:0]  gnt_q, gnt_d;
  logic [1:0]  rr_ptr_q, rr_ptr_d;
  logic [31:0] op1_q, op1_d;
  logic [31:0] op2_q, op2_d;
  alu_op_e     aluop_q, aluop_d;
  logic [31:0] result_q, result_d;
  logic        zero_q, zero_d;
  logic        err_q, err_d;

  logic [3:0]       vld4, rdy4, ready4, resp_vld4;
  logic [3:0][31:0] op1_ext, op2_ext;
  logic [3:0][3:0]  aluop_ext;
  logic [2:0]       pos;
  logic             gnt_found;
  logic [1:0]       gnt_idx;
  logic             accept;
  logic             legal;
  logic [31:0]      alu_result;

  // Widen per-requester inputs to the maximum of 4 so 2-bit indices are exact.
  assign vld4 = 4'(ifc.req_valid);
  assign rdy4 = 4'(ifc.resp_ready);

  always_comb begin
    op1_ext   = '0;
    op2_ext   = '0;
    aluop_ext = '0;
    for (int k = 0; k < NREQ; k++) begin
      op1_ext[k]   = ifc.req_op1[k];
      op2_ext[k]   = ifc.req_op2[k];
      aluop_ext[k] = ifc.req_aluop[k];
    end
  end

  // First valid requester scanning upward from rr_ptr with wrap (or from 0).
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    pos       = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos = ROUND_ROBIN ? (3'(rr_ptr_q) + 3'(k)) : 3'(k);
      if (pos >= 3'(NREQ)) pos = pos - 3'(NREQ);
      if (!gnt_found && vld4[pos[1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = pos[1:0];
      end
    end
  end

  alu_share_arbiter_alu u_alu (
    .a      (op1_q),
    .b      (op2_q),
    .op     (aluop_q),
    .result (alu_result)
  );

  assign legal  = is_legal_op(aluop_q);
  assign accept = (state_q == IDLE) && gnt_found && !reset;

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    rr_ptr_d  = rr_ptr_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    aluop_d   = aluop_q;
    result_d  = result_q;
    zero_d    = zero_q;
    err_d     = err_q;
    ready4    = '0;
    resp_vld4 = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          ready4[gnt_idx] = 1'b1;
          gnt_d           = gnt_idx;
          op1_d           = op1_ext[gnt_idx];
          op2_d           = op2_ext[gnt_idx];
          aluop_d         = alu_op_e'(aluop_ext[gnt_idx]);
          state_d         = EXEC;
        end
      end
      EXEC: begin
        result_d = legal ? alu_result : '0;
        zero_d   = legal && (aluop_q == ALU_SUB) && (alu_result == '0);
        err_d    = !legal;
        state_d  = RESP;
      end
      RESP: begin
        resp_vld4[gnt_q] = 1'b1;
        if (rdy4[gnt_q]) begin
          state_d  = IDLE;
          rr_ptr_d = (gnt_q == LAST_IDX) ? 2'd0 : gnt_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      rr_ptr_q <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      aluop_q  <= ALU_AND;
      result_q <= '0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      rr_ptr_q <= rr_ptr_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      aluop_q  <= aluop_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
    end
  end

  assign ifc.req_ready   = ready4[NREQ-1:0];
  assign ifc.resp_valid  = resp_vld4[NREQ-1:0];
  assign ifc.resp_result = result_q;
  assign ifc.resp_zero   = zero_q;
  assign ifc.resp_err    = err_q;
  assign busy            = (state_q != IDLE);
  assign state_dbg       = state_q;
  assign rr_ptr_dbg      = rr_ptr_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: one round-robin and one
// fixed-priority instance, hand-computed expected results.
module tb_alu_share_arbiter;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_share_arbiter_if #(.NREQ(2)) ifc_rr ();
  alu_share_arbiter_if #(.NREQ(2)) ifc_fp ();

  logic       busy_rr, busy_fp;
  arb_state_e st_rr, st_fp;
  logic [1:0] ptr_rr, ptr_fp;

  alu_share_arbiter #(.NREQ(2), .ROUND_ROBIN(1'b1)) dut_rr (
    .clk(clk), .reset(reset), .ifc(ifc_rr.slave),
    .busy(busy_rr), .state_dbg(st_rr), .rr_ptr_dbg(ptr_rr)
  );

  alu_share_arbiter #(.NREQ(2), .ROUND_ROBIN(1'b0)) dut_fp (
    .clk(clk), .reset(reset), .ifc(ifc_fp.slave),
    .busy(busy_fp), .state_dbg(st_fp), .rr_ptr_dbg(ptr_fp)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    ifc_rr.req_valid = '0; ifc_rr.req_op1 = '0; ifc_rr.req_op2 = '0;
    ifc_rr.req_aluop = '0; ifc_rr.resp_ready = '0;
    ifc_fp.req_valid = '0; ifc_fp.req_op1 = '0; ifc_fp.req_op2 = '0;
    ifc_fp.req_aluop = '0; ifc_fp.resp_ready = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_state"}, 32'(st_rr), 32'(IDLE));
    check({tag, "_rvalid"}, 32'(ifc_rr.resp_valid), 32'd0);
    check({tag, "_result"}, ifc_rr.resp_result, 32'd0);
    check({tag, "_zero"}, 32'(ifc_rr.resp_zero), 32'd0);
    check({tag, "_err"}, 32'(ifc_rr.resp_err), 32'd0);
    check({tag, "_rrptr"}, 32'(ptr_rr), 32'd0);
    check({tag, "_busy"}, 32'(busy_rr), 32'd0);
    check({tag, "_qready"}, 32'(ifc_rr.req_ready), 32'd0);
  endtask

  // Full single transaction on requester idx of the round-robin instance.
  task automatic run_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] op, input logic [31:0] exp_res,
                        input logic exp_zero, input logic exp_err, input string tag);
    exp_q.push_back(exp_res);
    @(negedge clk);
    ifc_rr.req_valid = 2'(1 << idx);
    ifc_rr.req_op1[idx] = a;
    ifc_rr.req_op2[idx] = b;
    ifc_rr.req_aluop[idx] = op;
    #1;
    check({tag, "_qready"}, 32'(ifc_rr.req_ready), 32'(1 << idx));
    @(posedge clk); #1;
    ifc_rr.req_valid = '0;
    check({tag, "_exec"}, 32'(st_rr), 32'(EXEC));
    check({tag, "_early"}, 32'(ifc_rr.resp_valid), 32'd0);
    @(posedge clk); #1;
    check({tag, "_rvalid"}, 32'(ifc_rr.resp_valid), 32'(1 << idx));
    check({tag, "_result"}, ifc_rr.resp_result, exp_q.pop_front());
    check({tag, "_zero"}, 32'(ifc_rr.resp_zero), 32'(exp_zero));
    check({tag, "_err"}, 32'(ifc_rr.resp_err), 32'(exp_err));
    ifc_rr.resp_ready = 2'(1 << idx);
    @(posedge clk); #1;
    ifc_rr.resp_ready = '0;
    check({tag, "_idle"}, 32'(st_rr), 32'(IDLE));
    check({tag, "_rrptr"}, 32'(ptr_rr), 32'((idx + 1) % 2));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int got_rr, got_fp, last_rr, last_fp;
    logic [1:0] exp_g_rr[4];
    reset = 1'b1;
    idle_inputs();
    do_reset();
    #1;
    check_quiet("reset");

    // Basic ops, SUB zero flag, wrap and overflow, illegal code.
    run_op(0, 32'd5, 32'd7, 4'b0010, 32'd12, 1'b0, 1'b0, "add");
    run_op(1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'b0110, 32'd0, 1'b1, 1'b0, "sub_eq");
    run_op(0, 32'd0, 32'd0, 4'b0000, 32'd0, 1'b0, 1'b0, "and_zero");
    run_op(1, 32'd0, 32'd1, 4'b0110, 32'hFFFF_FFFF, 1'b0, 1'b0, "sub_wrap");
    run_op(0, 32'hFFFF_FFFF, 32'd2, 4'b0010, 32'd1, 1'b0, 1'b0, "add_ovf");
    run_op(1, 32'hF0F0_0000, 32'h0F0F_00FF, 4'b0001, 32'hFFFF_00FF, 1'b0, 1'b0, "or");
    run_op(0, 32'd3, 32'd4, 4'b1111, 32'd0, 1'b0, 1'b1, "illegal");
    run_op(1, 32'd9, 32'd4, 4'b0110, 32'd5, 1'b0, 1'b0, "after_ill");
    run_op(0, 32'd8, 32'd5, 4'b0011, 32'd0, 1'b0, 1'b1, "illegal3");

    // Backpressure on requester 0 while requester 1 waits.
    exp_q.push_back(32'hA5A5_5A5A);
    @(negedge clk);
    ifc_rr.req_valid = 2'b01;
    ifc_rr.req_op1[0] = 32'hA5A5_0000;
    ifc_rr.req_op2[0] = 32'h0000_5A5A;
    ifc_rr.req_aluop[0] = 4'b0001;
    @(posedge clk); #1;
    ifc_rr.req_valid = 2'b10;
    ifc_rr.req_op1[1] = 32'd1;
    ifc_rr.req_op2[1] = 32'd1;
    ifc_rr.req_aluop[1] = 4'b0010;
    @(posedge clk); #1;
    for (int c = 0; c < 5; c++) begin
      check("bp_rvalid", 32'(ifc_rr.resp_valid), 32'b01);
      check("bp_result", ifc_rr.resp_result, 32'hA5A5_5A5A);
      check("bp_zero", 32'(ifc_rr.resp_zero), 32'd0);
      check("bp_busy", 32'(busy_rr), 32'd1);
      check("bp_qready", 32'(ifc_rr.req_ready), 32'd0);
      @(posedge clk); #1;
    end
    void'(exp_q.pop_front());
    ifc_rr.resp_ready = 2'b01;
    @(posedge clk); #1;
    ifc_rr.resp_ready = '0;
    check("bp_idle", 32'(st_rr), 32'(IDLE));
    check("bp_next_grant", 32'(ifc_rr.req_ready), 32'b10);
    ifc_rr.req_valid = '0;
    @(posedge clk); #1;
    check("bp_drop", 32'(st_rr), 32'(IDLE));

    // Contention: both requesters held valid, responses always consumed.
    do_reset();
    exp_g_rr = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_q = {32'd3, 32'h0000_00FF, 32'd3, 32'h0000_00FF};
    @(negedge clk);
    ifc_rr.req_valid = 2'b11; ifc_fp.req_valid = 2'b11;
    ifc_rr.req_op1 = {32'h0000_00F0, 32'd1}; ifc_fp.req_op1 = {32'h0000_00F0, 32'd1};
    ifc_rr.req_op2 = {32'h0000_000F, 32'd2}; ifc_fp.req_op2 = {32'h0000_000F, 32'd2};
    ifc_rr.req_aluop = {4'b0001, 4'b0010}; ifc_fp.req_aluop = {4'b0001, 4'b0010};
    ifc_rr.resp_ready = 2'b11; ifc_fp.resp_ready = 2'b11;
    got_rr = 0; got_fp = 0; last_rr = 0; last_fp = 0;
    for (int cyc = 0; cyc < 30 && (got_rr < 4 || got_fp < 4); cyc++) begin
      @(posedge clk); #1;
      if (ifc_rr.resp_valid != '0 && got_rr < 4) begin
        check("rr_grant", 32'(ifc_rr.resp_valid), 32'(exp_g_rr[got_rr]));
        check("rr_result", ifc_rr.resp_result, exp_q.pop_front());
        if (got_rr > 0) check("rr_spacing", 32'(cyc - last_rr), 32'd3);
        last_rr = cyc;
        got_rr++;
      end
      if (ifc_fp.resp_valid != '0 && got_fp < 4) begin
        check("fp_grant", 32'(ifc_fp.resp_valid), 32'b01);
        check("fp_result", ifc_fp.resp_result, 32'd3);
        if (got_fp > 0) check("fp_spacing", 32'(cyc - last_fp), 32'd3);
        last_fp = cyc;
        got_fp++;
      end
    end
    check("rr_count", 32'(got_rr), 32'd4);
    check("fp_count", 32'(got_fp), 32'd4);
    ifc_rr.req_valid = '0; ifc_fp.req_valid = '0;
    @(posedge clk); #1;
    ifc_rr.resp_ready = '0; ifc_fp.resp_ready = '0;

    // Reset during EXEC, then during RESP.
    do_reset();
    run_op(0, 32'd20, 32'd22, 4'b0010, 32'd42, 1'b0, 1'b0, "pre_rst");
    @(negedge clk);
    ifc_rr.req_valid = 2'b01;
    ifc_rr.req_op1[0] = 32'd5; ifc_rr.req_op2[0] = 32'd7; ifc_rr.req_aluop[0] = 4'b0010;
    @(posedge clk); #1;
    ifc_rr.req_valid = '0;
    check("rst_exec_pre", 32'(st_rr), 32'(EXEC));
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_quiet("rst_exec");
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("rst_exec_stale", 32'(ifc_rr.resp_valid), 32'd0);
    end

    @(negedge clk);
    ifc_rr.req_valid = 2'b10;
    ifc_rr.req_op1[1] = 32'd5; ifc_rr.req_op2[1] = 32'd5; ifc_rr.req_aluop[1] = 4'b0110;
    @(posedge clk); #1;
    ifc_rr.req_valid = '0;
    @(posedge clk); #1;
    check("rst_resp_pre", 32'(ifc_rr.resp_zero), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_quiet("rst_resp");
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("rst_resp_stale", 32'(ifc_rr.resp_valid), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
